// File: rtl/z3_autoconfig_master_pkg.sv
// Shared types and constants for the Zorro III autoconfig host initiator.
package z3_autoconfig_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_GAP,
    S_DECIDE,
    S_WR_REQ,
    S_WR_WAIT,
    S_FIN
  } ac_state_t;

  localparam logic [6:0] IDX_BASE         = 7'h22;
  localparam logic [6:0] IDX_SHUTUP       = 7'h26;
  localparam logic [6:0] LAST_IDX_DEFAULT = 7'h13;
  localparam logic [1:0] ER_TYPE_Z3       = 2'b10;

  // Nibble index to card address: ADDRL[5:0]=idx[6:1], ADDRL[6]=idx[0].
  function automatic logic [6:0] idx_to_addrl(input logic [6:0] idx);
    return {idx[0], idx[6:1]};
  endfunction

endpackage

// File: rtl/z3_ac_field_assembler.sv
// Assembles de-inverted expansion ROM fields from nibbles read by index.
module z3_ac_field_assembler
  import z3_autoconfig_master_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        clr,
  input  logic        strobe,
  input  logic [6:0]  idx,
  input  logic [3:0]  nibble,
  output logic [7:0]  er_type,
  output logic [7:0]  er_prod,
  output logic [7:0]  er_flags,
  output logic [15:0] mfg_id,
  output logic [31:0] serial
);

  logic [3:0] inv;
  assign inv = ~nibble;

  // Field registers: type nibbles stored as read, all others inverted; idx 06/07 dropped.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      er_type  <= '0;
      er_prod  <= '0;
      er_flags <= '0;
      mfg_id   <= '0;
      serial   <= '0;
    end else if (clr) begin
      er_type  <= '0;
      er_prod  <= '0;
      er_flags <= '0;
      mfg_id   <= '0;
      serial   <= '0;
    end else if (strobe) begin
      case (idx)
        7'h00: er_type[7:4]   <= nibble;
        7'h01: er_type[3:0]   <= nibble;
        7'h02: er_prod[7:4]   <= inv;
        7'h03: er_prod[3:0]   <= inv;
        7'h04: er_flags[7:4]  <= inv;
        7'h05: er_flags[3:0]  <= inv;
        7'h08: mfg_id[15:12]  <= inv;
        7'h09: mfg_id[11:8]   <= inv;
        7'h0A: mfg_id[7:4]    <= inv;
        7'h0B: mfg_id[3:0]    <= inv;
        7'h0C: serial[31:28]  <= inv;
        7'h0D: serial[27:24]  <= inv;
        7'h0E: serial[23:20]  <= inv;
        7'h0F: serial[19:16]  <= inv;
        7'h10: serial[15:12]  <= inv;
        7'h11: serial[11:8]   <= inv;
        7'h12: serial[7:4]    <= inv;
        7'h13: serial[3:0]    <= inv;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/z3_autoconfig_master.sv
// Zorro III autoconfig host initiator: enumerates card config nibbles, then configures or shuts up.
module z3_autoconfig_master
  import z3_autoconfig_master_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [6:0]  LAST_IDX = LAST_IDX_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic        allow_cfg,
  input  logic [3:0]  base_nibble,
  output logic        ac_cycle,
  output logic [6:0]  ADDRL,
  output logic        READ,
  output logic [3:0]  DOUT,
  input  logic [3:0]  DIN,
  input  logic        dtack,
  output logic        CFGIN_n,
  output logic        busy,
  output logic        done,
  output logic        card_present,
  output logic        configured,
  output logic        shut_up,
  output logic [7:0]  er_type,
  output logic [7:0]  er_prod,
  output logic [7:0]  er_flags,
  output logic [15:0] mfg_id,
  output logic [31:0] serial
);

  localparam logic [4:0] TMO_LAST = 5'(TIMEOUT - 1);

  ac_state_t  state, state_nx;
  logic [6:0] idx;
  logic [4:0] tcnt;
  logic [3:0] dout_q;
  logic       wr_cfg;
  logic       cap_stb;
  logic       tmo;
  logic       clr;

  assign tmo   = (tcnt == TMO_LAST);
  assign clr   = (state == S_IDLE) && start;
  assign ADDRL = idx_to_addrl(idx);
  assign DOUT  = dout_q;

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state and Moore bus/status outputs.
  always_comb begin
    state_nx = state;
    cap_stb  = 1'b0;
    ac_cycle = 1'b0;
    READ     = 1'b1;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_RD_REQ;
      end
      S_RD_REQ: begin
        ac_cycle = 1'b1;
        state_nx = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        ac_cycle = 1'b1;
        if (dtack) begin
          cap_stb  = 1'b1;
          state_nx = S_GAP;
        end else if (tmo) begin
          state_nx = S_FIN;
        end
      end
      S_GAP:    state_nx = (idx == LAST_IDX) ? S_DECIDE : S_RD_REQ;
      S_DECIDE: state_nx = S_WR_REQ;
      S_WR_REQ: begin
        ac_cycle = 1'b1;
        READ     = 1'b0;
        state_nx = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        ac_cycle = 1'b1;
        READ     = 1'b0;
        if (dtack || tmo) state_nx = S_FIN;
      end
      S_FIN: begin
        busy     = 1'b0;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign CFGIN_n = ~busy;

  // Index, timeout counter, write setup and result flags.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      idx          <= '0;
      tcnt         <= '0;
      dout_q       <= '0;
      wr_cfg       <= 1'b0;
      card_present <= 1'b0;
      configured   <= 1'b0;
      shut_up      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          idx          <= '0;
          dout_q       <= '0;
          card_present <= 1'b0;
          configured   <= 1'b0;
          shut_up      <= 1'b0;
        end
        S_RD_REQ, S_WR_REQ: tcnt <= '0;
        S_RD_WAIT: if (!dtack && tcnt != '1) tcnt <= tcnt + 5'd1;
        S_WR_WAIT: begin
          if (dtack) begin
            if (wr_cfg) configured <= 1'b1;
            else        shut_up    <= 1'b1;
          end else if (tcnt != '1) begin
            tcnt <= tcnt + 5'd1;
          end
        end
        S_GAP: if (idx != LAST_IDX) idx <= idx + 7'd1;
        S_DECIDE: begin
          card_present <= 1'b1;
          if (allow_cfg && er_type[7:6] == ER_TYPE_Z3) begin
            wr_cfg <= 1'b1;
            idx    <= IDX_BASE;
            dout_q <= base_nibble;
          end else begin
            wr_cfg <= 1'b0;
            idx    <= IDX_SHUTUP;
            dout_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  z3_ac_field_assembler u_fields (
    .CLK      (CLK),
    .RESET    (RESET),
    .clr      (clr),
    .strobe   (cap_stb),
    .idx      (idx),
    .nibble   (DIN),
    .er_type  (er_type),
    .er_prod  (er_prod),
    .er_flags (er_flags),
    .mfg_id   (mfg_id),
    .serial   (serial)
  );

endmodule

// File: tb/tb_z3_autoconfig_master.sv
// Scoreboard bench for z3_autoconfig_master with a behavioural autoconfig card.
module tb_z3_autoconfig_master;

  localparam int unsigned TMO = 16;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        start = 1'b0;
  logic        allow_cfg = 1'b0;
  logic [3:0]  base_nibble = '0;
  logic        ac_cycle;
  logic [6:0]  ADDRL;
  logic        READ;
  logic [3:0]  DOUT;
  logic [3:0]  DIN = '0;
  logic        dtack = 1'b0;
  logic        CFGIN_n, busy, done, card_present, configured, shut_up;
  logic [7:0]  er_type, er_prod, er_flags;
  logic [15:0] mfg_id;
  logic [31:0] serial;

  z3_autoconfig_master #(.TIMEOUT(TMO), .LAST_IDX(7'h13)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .allow_cfg(allow_cfg),
    .base_nibble(base_nibble), .ac_cycle(ac_cycle), .ADDRL(ADDRL), .READ(READ),
    .DOUT(DOUT), .DIN(DIN), .dtack(dtack), .CFGIN_n(CFGIN_n), .busy(busy),
    .done(done), .card_present(card_present), .configured(configured),
    .shut_up(shut_up), .er_type(er_type), .er_prod(er_prod), .er_flags(er_flags),
    .mfg_id(mfg_id), .serial(serial)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0]  typ, prod, flags;
    logic [15:0] mfg;
    logic [31:0] ser;
    logic        present, cfg, shut;
    int          nreads, nwrites, lat;
    logic [6:0]  waddr;
    logic [3:0]  wdata;
  } exp_t;

  exp_t exp_q[$];

  int cyc = 0;
  int start_cyc = 0;
  always @(posedge CLK) cyc++;

  // Behavioural card: ROM of raw bus nibbles, acks d cycles into each bus cycle.
  logic [3:0] rom [0:127];
  bit         card_en = 1'b1;
  int         card_dly = 1;
  int         rd_seen = 0, wr_seen = 0;
  logic [6:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  int         ac_len = 0, low_run = 0;
  bit         prev_ac = 1'b0, prev_was_read = 1'b0;
  logic [6:0] held_addr;
  logic       held_read;
  logic [3:0] held_dout;

  always @(negedge CLK) begin
    if (RESET) begin
      dtack = 1'b0; prev_ac = 1'b0; ac_len = 0; low_run = 0; prev_was_read = 1'b0;
    end else if (ac_cycle === 1'b1) begin
      if (!prev_ac) begin
        if (READ === 1'b1 && prev_was_read && rd_seen > 0) chk("gap_len", 64'(low_run), 64'd1);
        held_addr = ADDRL; held_read = READ; held_dout = DOUT; ac_len = 0;
        if (READ === 1'b1) rd_seen++;
        else begin wr_seen++; wr_addr = ADDRL; wr_data = DOUT; end
      end else begin
        chk("addr_stable", 64'(ADDRL), 64'(held_addr));
        chk("read_stable", 64'(READ), 64'(held_read));
        if (held_read === 1'b0) chk("dout_stable", 64'(DOUT), 64'(held_dout));
      end
      ac_len++;
      if (card_en && ac_len >= card_dly) begin
        dtack = 1'b1;
        DIN = rom[{ADDRL[5:0], ADDRL[6]}];
      end else begin
        dtack = 1'b0;
        DIN = 4'($urandom);
      end
      low_run = 0;
      prev_was_read = (READ === 1'b1);
    end else begin
      dtack = 1'b0;
      DIN = 4'($urandom);
      low_run++;
    end
    prev_ac = (ac_cycle === 1'b1);
  end

  // Monitor: on each done pulse compare DUT results with the next expectation.
  bit prev_done = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (prev_done) chk("done_pulse_width", 64'(done), 64'd0);
    if (!RESET && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("er_type", 64'(er_type), 64'(e.typ));
        chk("er_prod", 64'(er_prod), 64'(e.prod));
        chk("er_flags", 64'(er_flags), 64'(e.flags));
        chk("mfg_id", 64'(mfg_id), 64'(e.mfg));
        chk("serial", 64'(serial), 64'(e.ser));
        chk("card_present", 64'(card_present), 64'(e.present));
        chk("configured", 64'(configured), 64'(e.cfg));
        chk("shut_up", 64'(shut_up), 64'(e.shut));
        chk("read_count", 64'(rd_seen), 64'(e.nreads));
        chk("write_count", 64'(wr_seen), 64'(e.nwrites));
        if (e.nwrites > 0) begin
          chk("write_addr", 64'(wr_addr), 64'(e.waddr));
          chk("write_data", 64'(wr_data), 64'(e.wdata));
        end
        chk("latency", 64'(cyc - start_cyc), 64'(e.lat));
        chk("fin_cfgin_n", 64'(CFGIN_n), 64'd1);
        chk("fin_busy", 64'(busy), 64'd0);
        chk("fin_ac_cycle", 64'(ac_cycle), 64'd0);
        chk("fin_read", 64'(READ), 64'd1);
      end
    end
    prev_done = (done === 1'b1);
  end

  task automatic load_card(input logic [7:0] typ, input logic [7:0] prod, input logic [7:0] flags,
                           input logic [15:0] mfg, input logic [31:0] ser);
    rom[0] = typ[7:4];
    rom[1] = typ[3:0];
    rom[2] = ~prod[7:4];
    rom[3] = ~prod[3:0];
    rom[4] = ~flags[7:4];
    rom[5] = ~flags[3:0];
    rom[6] = 4'($urandom);
    rom[7] = 4'($urandom);
    for (int i = 0; i < 4; i++) rom[8 + i] = ~mfg[15 - 4*i -: 4];
    for (int i = 0; i < 8; i++) rom[12 + i] = ~ser[31 - 4*i -: 4];
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic run(input logic [7:0] typ, input logic [7:0] prod, input logic [7:0] flags,
                     input logic [15:0] mfg, input logic [31:0] ser, input bit en, input int d,
                     input bit allow, input logic [3:0] base, input bit dbl_start);
    exp_t e;
    int   a;
    bit   ok, z3cfg, seen;
    load_card(typ, prod, flags, mfg, ser);
    a  = (d < 2) ? 2 : d;
    ok = en && (a - 1 <= int'(TMO));
    z3cfg = allow && (typ[7:6] == 2'b10);
    e.typ   = ok ? typ : '0;
    e.prod  = ok ? prod : '0;
    e.flags = ok ? flags : '0;
    e.mfg   = ok ? mfg : '0;
    e.ser   = ok ? ser : '0;
    e.present = ok;
    e.cfg   = ok && z3cfg;
    e.shut  = ok && !z3cfg;
    e.nreads  = ok ? 20 : 1;
    e.nwrites = ok ? 1 : 0;
    e.waddr = z3cfg ? 7'h11 : 7'h13;
    e.wdata = z3cfg ? base : 4'h0;
    e.lat   = ok ? (20 * (a + 1) + 1 + a + 1) : (int'(TMO) + 2);
    card_en = en; card_dly = d;
    allow_cfg = allow; base_nibble = base;
    rd_seen = 0; wr_seen = 0;
    exp_q.push_back(e);
    start_cyc = cyc;
    pulse_start();
    if (dbl_start) begin
      repeat (9) @(negedge CLK);
      pulse_start();
    end
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge CLK);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      chk("done_wait_expired", 64'd0, 64'd1);
      exp_q.delete();
    end
    // Disturb inputs afterwards; results must hold.
    allow_cfg = ~allow_cfg; base_nibble = ~base_nibble;
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    bit found;
    #1;
    chk("rst_ac_cycle", 64'(ac_cycle), 64'd0);
    chk("rst_addrl", 64'(ADDRL), 64'd0);
    chk("rst_read", 64'(READ), 64'd1);
    chk("rst_dout", 64'(DOUT), 64'd0);
    chk("rst_cfgin_n", 64'(CFGIN_n), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_flags", 64'({card_present, configured, shut_up}), 64'd0);
    chk("rst_fields", 64'({er_type, er_prod, er_flags, mfg_id, serial} != '0), 64'd0);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    run(8'hA4, 8'h03, 8'hB1, 16'h144A, 32'h12345678, 1'b1, 1, 1'b1, 4'h4, 1'b0);
    run(8'hA4, 8'h03, 8'hB1, 16'h144A, 32'h12345678, 1'b1, 1, 1'b0, 4'h4, 1'b0);
    run(8'hC4, 8'h03, 8'hB1, 16'h144A, 32'h12345678, 1'b1, 1, 1'b1, 4'h4, 1'b0);
    run(8'hA4, 8'h03, 8'hB1, 16'h144A, 32'h12345678, 1'b0, 1, 1'b1, 4'h4, 1'b0);
    run(8'hA4, 8'h03, 8'hB1, 16'h144A, 32'h12345678, 1'b1, 1, 1'b1, 4'h9, 1'b1);

    // Abort mid-enumeration with RESET while reading nibble 7.
    load_card(8'hA4, 8'h03, 8'hB1, 16'h144A, 32'h12345678);
    card_en = 1'b1; card_dly = 2; allow_cfg = 1'b1; rd_seen = 0; wr_seen = 0;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge CLK);
      if (ac_cycle === 1'b1 && ADDRL === 7'h43) found = 1'b1;
    end
    chk("reached_idx7", 64'(found), 64'd1);
    RESET = 1'b1;
    #1;
    chk("abort_ac_cycle", 64'(ac_cycle), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_cfgin_n", 64'(CFGIN_n), 64'd1);
    chk("abort_fields", 64'({er_type, er_prod, er_flags, mfg_id, serial} != '0), 64'd0);
    chk("abort_flags", 64'({card_present, configured, shut_up}), 64'd0);
    chk("abort_no_write", 64'(wr_seen), 64'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    run(8'hA4, 8'h03, 8'hB1, 16'h144A, 32'h12345678, 1'b1, 1, 1'b1, 4'h4, 1'b0);

    run(8'hA4, 8'h03, 8'hB1, 16'h144A, 32'h12345678, 1'b1, 5, 1'b1, 4'h4, 1'b0);
    run(8'h93, 8'h5A, 8'h0F, 16'hBEEF, 32'hCAFEF00D, 1'b1, int'(TMO) + 1, 1'b1, 4'hE, 1'b0);
    run(8'h93, 8'h5A, 8'h0F, 16'hBEEF, 32'hCAFEF00D, 1'b1, int'(TMO) + 2, 1'b1, 4'hE, 1'b0);

    for (int n = 0; n < 8; n++) begin
      logic [7:0] t;
      t = 8'($urandom);
      if ($urandom_range(0, 1) == 1) t[7:6] = 2'b10;
      run(t, 8'($urandom), 8'($urandom), 16'($urandom), 32'($urandom),
          ($urandom_range(0, 7) != 0), int'($urandom_range(1, 6)),
          1'($urandom), 4'($urandom), 1'b0);
    end

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/z3_autoconfig_master.md
Name: z3_autoconfig_master

Overview:
Host-side initiator for the Zorro III autoconfig nibble protocol used by our RAM card. On a start pulse it walks the card's config space one nibble per bus cycle and de-inverts/assembles the expansion ROM fields. It then either writes a base address nibble (card configured) or issues shutup. Used in the bring-up harness and the system-level bench to drive the card's autoconfig responder exactly as Kickstart would.

Parameters:
TIMEOUT, 16, CLK cycles to wait for DTACK before abandoning a cycle (minimum 2)
LAST_IDX, 7'h13, last nibble index read during enumeration

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous reset, active-high
start  in  1  single-cycle pulse; begin enumeration (ignored unless idle)
allow_cfg  in  1  1 = assign base address, 0 = force shutup
base_nibble  in  4  base address nibble written on configure
ac_cycle  out  1  autoconfig bus cycle active (to card autoconfig_cycle)
ADDRL  out  7  card address; nibble index idx maps to ADDRL[5:0]=idx[6:1], ADDRL[6]=idx[0]
READ  out  1  1 = read cycle, 0 = write cycle
DOUT  out  4  write data to card
DIN  in  4  read data from card
dtack  in  1  card acknowledge
CFGIN_n  out  1  config-in to card; low from start until done
busy  out  1  enumeration in progress
done  out  1  one-cycle pulse at completion
card_present  out  1  1 = all reads acknowledged
configured  out  1  base nibble write acknowledged
shut_up  out  1  shutup write acknowledged
er_type  out  8  {n00,n01}, not inverted
er_prod  out  8  ~{n02,n03}
er_flags  out  8  ~{n04,n05}
mfg_id  out  16  ~{n08..n0B}
serial  out  32  ~{n0C..n13}

Behaviour:
- Reset: all outputs 0 except CFGIN_n=1, READ=1; state IDLE; idx=0; timeout counter 0.
- States: IDLE, RD_REQ, RD_WAIT, GAP, DECIDE, WR_REQ, WR_WAIT, FIN.
- IDLE: on start -> RD_REQ, idx=0, busy=1, CFGIN_n=0, clear card_present/configured/shut_up and all er_* fields.
- RD_REQ: drive ADDRL(idx), READ=1, ac_cycle=1 -> RD_WAIT; counter=0.
- RD_WAIT: ac_cycle, ADDRL, READ held stable. dtack sampled high -> capture DIN into nibble slot idx (inversion per port list; idx 06/07 discarded) -> GAP. No dtack for TIMEOUT cycles -> FIN with card_present=0.
- GAP: ac_cycle=0 for exactly one cycle (card dtack returns low). If idx==LAST_IDX -> DECIDE, else idx+1 -> RD_REQ.
- DECIDE: card_present=1. allow_cfg=1 and er_type[7:6]==2'b10 -> configure write (ADDRL[5:0]=6'h11, ADDRL[6]=0, DOUT=base_nibble); otherwise shutup write (ADDRL[5:0]=6'h13, ADDRL[6]=0, DOUT=0). -> WR_REQ.
- WR_REQ/WR_WAIT: as read but READ=0, DOUT stable. dtack -> set configured or shut_up accordingly -> FIN. Timeout -> FIN with neither flag set.
- FIN: ac_cycle=0, READ=1, CFGIN_n=1, busy=0, done=1 for one cycle -> IDLE. Result flags and fields hold until the next start.
- Read latency per nibble: 1 (REQ) + dtack wait + 1 (GAP); minimum 3 cycles with dtack one cycle after request.
- allow_cfg and base_nibble are sampled in DECIDE only.
- start while busy is ignored. dtack outside a WAIT state is ignored.
- Reset mid-operation aborts immediately: ac_cycle=0, CFGIN_n=1, no partial write is issued.
- Timeout counter is 5 bits (sized for TIMEOUT ≤ 31) and saturates; a timeout fires when the counter reaches TIMEOUT-1 with no dtack.

Decomposition:
- Shared package/header: state encoding, nibble index constants (IDX_BASE=7'h22, IDX_SHUTUP=7'h26, LAST_IDX), ER_TYPE_Z3=2'b10.
- One natural sub-module: z3_ac_field_assembler (idx + nibble + strobe -> er_* registers, including the inversion rules).
- The FSM and bus driver stay in the top.

Test Plan:
- Card model returns type 0xA4, prod 0x03, flags 0xB1, mfg 5194, serial 0x12345678 (nibbles inverted per protocol), dtack 1 cycle late, allow_cfg=1, base_nibble=4'h4 -> er_type=8'hA4, er_prod=8'h03, er_flags=8'hB1, mfg_id=16'h144A, serial=32'h12345678; one write with ADDRL[5:0]=6'h11, DOUT=4'h4; configured=1; done pulse after 20 reads.
- Same card, allow_cfg=0 -> write at ADDRL[5:0]=6'h13; shut_up=1, configured=0.
- Card type nibble 4'b1100 (Zorro II), allow_cfg=1 -> shutup write issued; shut_up=1.
- Card never asserts dtack -> after TIMEOUT cycles on idx 0: done=1, card_present=0, no write, CFGIN_n back to 1.
- Second start pulse while busy, plus RESET asserted at idx 7 -> second start ignored; after reset ac_cycle=0, busy=0, all fields 0, a subsequent start re-enumerates correctly.
- dtack delayed by 5 cycles on every nibble -> ADDRL/READ stable throughout each wait, ac_cycle low exactly one cycle between cycles, results identical to scenario 1.
